// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: matrix geometry,
// key index type, column drive reset value and the scan column states.
package keypad_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int NUM_KEYS  = NUM_ROWS * NUM_COLS;
  localparam int KEY_IDX_W = 4;

  // Column 0 is driven low (active) first after reset.
  localparam logic [NUM_COLS-1:0] KEY_COL_RESET = 4'b1110;

  // Key index: row*NUM_COLS + col.
  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  // The scanner walks the columns in order; the state is the column
  // currently being driven (and sampled on the next edge).
  typedef enum logic [1:0] {
    SCAN_COL0 = 2'd0,
    SCAN_COL1 = 2'd1,
    SCAN_COL2 = 2'd2,
    SCAN_COL3 = 2'd3
  } scan_state_t;

  // Active-low one-hot column drive pattern for a given scan column.
  function automatic logic [NUM_COLS-1:0] col_drive(input scan_state_t s);
    logic [NUM_COLS-1:0] one_hot;
    one_hot    = '0;
    one_hot[s] = 1'b1;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/keypad_prio_enc.sv
// Lowest-index priority encoder over the 16-key map. Used to pick the single
// key that gets reported when several keys become pressed in the same commit.
module keypad_prio_enc
  import keypad_pkg::*;
(
  input  logic [NUM_KEYS-1:0] keys,
  output key_idx_t            idx,
  output logic                any_set
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        idx = key_idx_t'(i);
      end
    end
  end

  assign any_set = |keys;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debouncing and press events.
// Drives one column low per clock, samples the active-low rows, assembles a
// 16-bit frame every 4 clocks and commits it to key_map once DEBOUNCE_SCANS
// consecutive identical frames have been seen. Each commit that adds pressed
// keys produces one key_valid pulse carrying the lowest newly pressed index.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat for a single held
// key (REPEAT_DELAY frames to the first repeat, then every REPEAT_PERIOD).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 2
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_PERIOD  = 10
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [NUM_COLS-1:0] keyboard_col,
  input  logic [NUM_ROWS-1:0] keyboard_row,
  output logic                key_valid,
  output logic [KEY_IDX_W-1:0] key_code,
  output logic                key_down,
  output logic [NUM_KEYS-1:0] key_map
);

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

  scan_state_t          state;
  scan_state_t          state_next;
  logic [NUM_KEYS-1:0]  raw_frame;
  logic [NUM_KEYS-1:0]  cur_frame;
  logic [NUM_KEYS-1:0]  last_frame;
  logic [NUM_KEYS-1:0]  new_keys;
  logic [3:0]           match_cnt;
  logic [3:0]           match_next;
  logic                 frame_end;
  logic                 commit;
  logic                 report;
  logic                 rep_fire;
  key_idx_t             new_idx;
  logic                 new_any;

  // Column walk: always advance to the next column, wrapping 3 -> 0.
  always_comb begin
    state_next = SCAN_COL0;
    case (state)
      SCAN_COL0: state_next = SCAN_COL1;
      SCAN_COL1: state_next = SCAN_COL2;
      SCAN_COL2: state_next = SCAN_COL3;
      SCAN_COL3: state_next = SCAN_COL0;
      default:   state_next = SCAN_COL0;
    endcase
  end

  // Merge the rows of the column driven this cycle into the partial frame;
  // on the last column this is the complete frame.
  always_comb begin
    cur_frame = raw_frame;
    for (int r = 0; r < NUM_ROWS; r++) begin
      cur_frame[r * NUM_COLS + int'(state)] = ~keyboard_row[r];
    end
  end

  // Debounce: count identical consecutive frames, saturating at the target,
  // and commit the frame whenever the count sits at the target.
  always_comb begin
    frame_end  = (state == SCAN_COL3);
    match_next = match_cnt;
    commit     = 1'b0;
    if (frame_end) begin
      if (cur_frame == last_frame) begin
        match_next = (match_cnt >= DEB_TARGET) ? DEB_TARGET : match_cnt + 4'd1;
      end else begin
        match_next = 4'd1;
      end
      commit = (match_next == DEB_TARGET);
    end
  end

  // Only keys that were not already in the stable map count as new presses.
  assign new_keys = cur_frame & ~key_map;
  assign report   = commit && new_any;

  keypad_prio_enc u_prio_enc (
    .keys    (new_keys),
    .idx     (new_idx),
    .any_set (new_any)
  );

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [15:0] REP_DELAY_W  = 16'(REPEAT_DELAY);
  localparam logic [15:0] REP_PERIOD_W = 16'(REPEAT_PERIOD);

  logic [15:0] rep_cnt;
  logic [15:0] rep_cnt_next;
  logic [15:0] rep_target;
  logic        rep_armed;
  logic        rep_armed_next;

  // Count frames while a single key is held with an unchanged map; the first
  // repeat waits REPEAT_DELAY frames, later ones REPEAT_PERIOD frames.
  always_comb begin
    rep_cnt_next   = rep_cnt;
    rep_armed_next = rep_armed;
    rep_fire       = 1'b0;
    rep_target     = rep_armed ? REP_PERIOD_W : REP_DELAY_W;
    if (frame_end) begin
      if ((commit && (cur_frame != key_map)) || !$onehot(key_map)) begin
        rep_cnt_next   = '0;
        rep_armed_next = 1'b0;
      end else if (rep_cnt + 16'd1 == rep_target) begin
        rep_fire       = 1'b1;
        rep_cnt_next   = '0;
        rep_armed_next = 1'b1;
      end else begin
        rep_cnt_next   = rep_cnt + 16'd1;
      end
    end
  end

  // Auto-repeat frame counter and first/subsequent repeat phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_next;
      rep_armed <= rep_armed_next;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scan state, column drive, frame assembly, debounce and report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCAN_COL0;
      keyboard_col <= KEY_COL_RESET;
      raw_frame    <= '0;
      last_frame   <= '0;
      match_cnt    <= '0;
      key_map      <= '0;
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_down     <= 1'b0;
    end else begin
      state        <= state_next;
      keyboard_col <= col_drive(state_next);
      raw_frame    <= cur_frame;
      key_valid    <= report || rep_fire;
      if (frame_end) begin
        last_frame <= cur_frame;
        match_cnt  <= match_next;
      end
      if (commit) begin
        key_map  <= cur_frame;
        key_down <= |cur_frame;
      end
      if (report) begin
        key_code <= new_idx;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner. A behavioural 4x4 key matrix drives
// the rows from the scanned columns; expected key_valid events (key code and
// edge number since reset release) are queued when keys are applied and
// compared when the DUT pulses key_valid.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  keyboard_col;
  logic [3:0]  keyboard_row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] key_map;

  logic [15:0] pressed;
  int          edge_cnt;
  int          check_count = 0;
  int          err_count   = 0;

  typedef struct {
    int code;
    int edge_no;
  } exp_t;

  exp_t exp_q[$];

  keypad_scanner #(
    .DEBOUNCE_SCANS (2)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (3),
    .REPEAT_PERIOD  (2)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keyboard_col (keyboard_col),
    .keyboard_row (keyboard_row),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_down     (key_down),
    .key_map      (key_map)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    keyboard_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r * 4 + c] && !keyboard_col[c]) begin
          keyboard_row[r] = 1'b0;
        end
      end
    end
  end

  // Edge number since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)",
               tag, actual, expected, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic goto_edge(input int n);
    repeat (n - edge_cnt) @(negedge clk);
  endtask

  task automatic push_expect(input int code, input int edge_no);
    exp_t e;
    e.code    = code;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 32'(key_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("pulse_code", 32'(key_code), 32'(e.code));
        checkOutput("pulse_edge", 32'(edge_cnt), 32'(e.edge_no));
      end
    end
  end

  logic [3:0] col_seq [4];

  initial begin
    col_seq[0] = 4'b1110;
    col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111;

    // Key 6 (row1/col2) held through reset release.
    rst_n = 1'b0;
    applyStimulus(16'h0040);
    repeat (3) @(negedge clk);
    checkOutput("rst_col",   32'(keyboard_col), 32'h0000000E);
    checkOutput("rst_map",   32'(key_map),      32'h0);
    checkOutput("rst_valid", 32'(key_valid),    32'h0);
    checkOutput("rst_code",  32'(key_code),     32'h0);
    checkOutput("rst_down",  32'(key_down),     32'h0);
    push_expect(6, 8);
    rst_n = 1'b1;

    goto_edge(7);
    checkOutput("pre_commit_map", 32'(key_map), 32'h0);
    goto_edge(8);
    checkOutput("k6_map",  32'(key_map),  32'h0040);
    checkOutput("k6_down", 32'(key_down), 32'h1);
    checkOutput("k6_code", 32'(key_code), 32'h6);

    // Release: map clears two frames later without a pulse.
    applyStimulus(16'h0000);
    goto_edge(12);
    checkOutput("hold_code", 32'(key_code), 32'h6);
    checkOutput("rel_map_pending", 32'(key_map), 32'h0040);
    goto_edge(16);
    checkOutput("rel_map",  32'(key_map),  32'h0);
    checkOutput("rel_down", 32'(key_down), 32'h0);

    // Keys 3 and 9 together: one report for key 3 only.
    applyStimulus(16'h0208);
    push_expect(3, 24);
    goto_edge(24);
    checkOutput("dual_map",  32'(key_map),  32'h0208);
    checkOutput("dual_down", 32'(key_down), 32'h1);
    goto_edge(32);
    checkOutput("dual_hold_map", 32'(key_map), 32'h0208);
    applyStimulus(16'h0000);
    goto_edge(40);
    checkOutput("dual_rel_map", 32'(key_map), 32'h0);

    // Bouncing key 0: toggles every frame, never commits.
    for (int f = 0; f < 20; f++) begin
      applyStimulus(f[0] ? 16'h0000 : 16'h0001);
      for (int j = 0; j < 4; j++) begin
        checkOutput("col_drive", 32'(keyboard_col), 32'(col_seq[j]));
        @(negedge clk);
      end
      checkOutput("bounce_map", 32'(key_map), 32'h0);
    end
    applyStimulus(16'h0000);

    // Key 6 reported, then reset asserted mid-frame at column 2.
    applyStimulus(16'h0040);
    push_expect(6, 128);
    goto_edge(130);
    checkOutput("pre_rst_map", 32'(key_map), 32'h0040);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_col",   32'(keyboard_col), 32'h0000000E);
    checkOutput("mid_rst_map",   32'(key_map),      32'h0);
    checkOutput("mid_rst_valid", 32'(key_valid),    32'h0);
    checkOutput("mid_rst_code",  32'(key_code),     32'h0);
    checkOutput("mid_rst_down",  32'(key_down),     32'h0);
    repeat (2) @(negedge clk);
    push_expect(6, 8);
    rst_n = 1'b1;
    goto_edge(8);
    checkOutput("rerpt_map",  32'(key_map),  32'h0040);
    checkOutput("rerpt_code", 32'(key_code), 32'h6);
    applyStimulus(16'h0000);
    goto_edge(16);
    checkOutput("rerpt_rel_map", 32'(key_map), 32'h0);

    // Single key 15 held for many frames.
    applyStimulus(16'h8000);
    push_expect(15, 24);
`ifdef KEYPAD_AUTOREPEAT_EN
    push_expect(15, 36);
    push_expect(15, 44);
    push_expect(15, 52);
`endif
    goto_edge(24);
    checkOutput("k15_map", 32'(key_map), 32'h8000);
    goto_edge(54);
    applyStimulus(16'h0000);
    goto_edge(60);
    checkOutput("k15_rel_map", 32'(key_map), 32'h0);

    goto_edge(80);
    checkOutput("pending_events", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_count, err_count);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans the 4x4 matrix keyboard that gomoku_main uses for board-cursor and move entry, debounces the scan results frame by frame, and reports each new key press as a one-cycle event with a 4-bit key code. It sits directly upstream of gomoku_main in top_maxii, driven by kb_scan_clk (100 Hz). It replaces raw keyboard_row/keyboard_col handling inside the game logic with a clean event interface.

Parameters:
DEBOUNCE_SCANS, 2, consecutive identical full-scan frames required before the stable key map updates; legal range 1..15
REPEAT_DELAY, 50, frames a single key must be held before the first auto-repeat; used only with KEYPAD_AUTOREPEAT_EN
REPEAT_PERIOD, 10, frames between subsequent auto-repeats; used only with KEYPAD_AUTOREPEAT_EN

Ports:
clk  input  1  scan clock, kb_scan_clk in the top level
rst_n  input  1  asynchronous reset, active low
keyboard_col  output  4  column drive, active-low one-hot
keyboard_row  input  4  row sense, active low (pulled up), bit r = row r
key_valid  output  1  one-cycle pulse: new press reported
key_code  output  4  index of the reported key = row*4 + col; held until the next report
key_down  output  1  level: at least one key is set in the stable map
key_map  output  16  debounced pressed map, bit index = row*4 + col

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active low.
- Reset values: col counter 0, keyboard_col=4'b1110, raw frame 0, last_frame 0, match_cnt 0, key_map 0, key_valid 0, key_code 0, key_down 0.
- Column drive: 2-bit counter cnt advances by 1 every clk edge and wraps 3->0. keyboard_col is registered and equals ~(1<<cnt).
- Sampling: at each edge, ~keyboard_row is written into frame bits {r*4+cnt} using the pre-increment cnt. This samples the column that was driven for the whole previous cycle. No synchronizer is used; the scan clock is slow relative to settling.
- Frame end: the edge with cnt==3 completes a frame of 16 bits, with column 3 merged in combinationally.
  - If frame==last_frame: match_cnt = min(match_cnt+1, DEBOUNCE_SCANS). Otherwise match_cnt = 1.
  - last_frame <= frame.
  - If the new match_cnt == DEBOUNCE_SCANS: key_map <= frame (commit).
- Press report: on a commit edge, new = frame & ~key_map(old). If new != 0, key_valid=1 and key_code=lowest set index of new, both on the same edge as the key_map update. key_valid clears on the next edge.
- Boundary rules:
  - Other keys newly pressed in the same commit are never reported.
  - Releases never produce key_valid.
  - Repeated commits of an unchanged map produce no report.
- key_down = |key_map, registered, updated together with key_map.
- Latency: a key held from before reset release is reported at edge 4*DEBOUNCE_SCANS after reset release.
- Bouncing input: frames that alternate reset match_cnt to 1 every frame, so no commit occurs while bouncing when DEBOUNCE_SCANS>=2. DEBOUNCE_SCANS=1 commits every frame.
- Reset mid-frame: the partial frame is discarded and scanning restarts at column 0.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: while key_map has exactly one bit set and is unchanged, a frame counter runs. key_valid re-pulses with the same key_code after REPEAT_DELAY frames, then every REPEAT_PERIOD frames. Any change to key_map restarts the counter. Repeat pulses coincide with a frame-end edge.
- Undefined: no repeat logic or counter is present; one report per press.

Decomposition:
- Package keypad_pkg holds:
  - NUM_ROWS=4 and NUM_COLS=4
  - key index width 4
  - KEY_COL_RESET=4'b1110
  - the key index typedef
- One sub-module, keypad_prio_enc: 16-bit input to lowest-set 4-bit index plus any-set flag. It is used for the key_code selection.
- The scan/debounce FSM stays in keypad_scanner.

Test Plan:
- Hold row1/col2 through reset release with DEBOUNCE_SCANS=2 -> key_valid high only at edge 8, key_code=6, key_map=16'h0040, key_down=1.
- Release that key and keep rows high -> key_map=0 two frames later, key_down=0, no key_valid pulse.
- Press keys 3 and 9 in the same frame -> a single pulse with key_code=3, key_map=16'h0208, and no later pulse for 9.
- Toggle row0/col0 every frame for 20 frames -> key_map stays 0 and key_valid never asserts; keyboard_col cycles 1110,1101,1011,0111.
- Assert rst_n low at cnt=2 with a key pressed -> all outputs return to reset values immediately; after release the key is reported again at edge 8.
- With KEYPAD_AUTOREPEAT_EN and REPEAT_DELAY=3, REPEAT_PERIOD=2, hold key 15 -> pulses at commit, commit+3 frames, then every 2 frames, all with key_code=15.
